// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: command-driven LED counter with an IDLE/RUN sequencer, prescaled tick,
//   programmable wrap limit and a one-cycle wrap pulse.
// Ports: clk/rst_n (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_data command
//   handshake; leds (count), running (RUN state), wrap (pulse after each wrap-around).
// Optional feature: define LED_SEQ_DIR_EN to enable TOGGLE_DIR and down-counting;
//   otherwise TOGGLE_DIR is a NOP and there is no direction register.
module led_seq_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] leds,
  output logic             running,
  output logic             wrap
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_START      = 3'd1;
  localparam logic [2:0] OP_STOP       = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_LOAD       = 3'd4;
  localparam logic [2:0] OP_SET_LIMIT  = 3'd5;
  localparam logic [2:0] OP_CLEAR      = 3'd6;
  localparam logic [2:0] OP_TOGGLE_DIR = 3'd7;

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] LIMIT_RST = WIDTH'(7);

  logic [0:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             wrap_q, wrap_d;
  logic             ready_q, ready_d;
`ifdef LED_SEQ_DIR_EN
  logic             dir_down_q, dir_down_d;
`endif

  logic             accept;
  logic             tick;
  logic [WIDTH-1:0] tick_val;
  logic             tick_wrap;

  assign accept = cmd_valid && ready_q;
  assign tick   = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

  // Result of one count step; shared by the prescaled tick and by STEP.
  always_comb begin
    tick_val  = leds_q + WIDTH'(1);
    tick_wrap = 1'b0;
    if (leds_q == limit_q) begin
      tick_val  = '0;
      tick_wrap = 1'b1;
    end
`ifdef LED_SEQ_DIR_EN
    if (dir_down_q) begin
      tick_val  = leds_q - WIDTH'(1);
      tick_wrap = 1'b0;
      if (leds_q == '0) begin
        tick_val  = limit_q;
        tick_wrap = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    leds_d  = leds_q;
    limit_d = limit_q;
    wrap_d  = 1'b0;
    // One dead cycle after every accept, ready otherwise.
    ready_d = ~accept;
`ifdef LED_SEQ_DIR_EN
    dir_down_d = dir_down_q;
`endif

    if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // An accepted command wins over a coincident tick; the tick is dropped.
    if (accept) begin
      case (cmd_op)
        OP_NOP: ;
        OP_START: begin
          state_d = ST_RUN;
          presc_d = '0;
        end
        OP_STOP: begin
          state_d = ST_IDLE;
          presc_d = presc_q;  // freeze; START clears it on resume
        end
        OP_STEP: begin
          if (state_q == ST_IDLE) begin
            leds_d = tick_val;
            wrap_d = tick_wrap;
          end
        end
        OP_LOAD: begin
          leds_d  = (cmd_data <= limit_q) ? cmd_data : '0;
          presc_d = '0;
        end
        OP_SET_LIMIT: begin
          limit_d = cmd_data;
          if (leds_q > cmd_data) leds_d = '0;
        end
        OP_CLEAR: begin
          leds_d  = '0;
          presc_d = '0;
        end
        OP_TOGGLE_DIR: begin
`ifdef LED_SEQ_DIR_EN
          dir_down_d = ~dir_down_q;
`endif
        end
        default: ;
      endcase
    end else if (tick) begin
      leds_d = tick_val;
      wrap_d = tick_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      leds_q  <= '0;
      limit_q <= LIMIT_RST;
      wrap_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      leds_q  <= leds_d;
      limit_q <= limit_d;
      wrap_q  <= wrap_d;
      ready_q <= ready_d;
    end
  end

`ifdef LED_SEQ_DIR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_down_q <= 1'b0;
    else        dir_down_q <= dir_down_d;
  end
`endif

  assign cmd_ready = ready_q;
  assign leds      = leds_q;
  assign running   = (state_q == ST_RUN);
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl (TICK_DIV=4, WIDTH=8).
// The stimulus pushes each expected output vector with the cycle it should appear in;
// a monitor pops one entry whenever {running, cmd_ready, wrap, leds} changes.
module tb_led_seq_ctrl;

  localparam logic [2:0] NOP = 3'd0, START = 3'd1, STOP = 3'd2, STEP = 3'd3;
  localparam logic [2:0] LOAD = 3'd4, SETLIM = 3'd5, CLEAR = 3'd6, TOGGLE = 3'd7;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] leds;
  logic       running;
  logic       wrap;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic       run;
    logic       rdy;
    logic       wr;
    logic [7:0] led;
  } obs_t;

  obs_t sb_q[$];

  led_seq_ctrl #(.TICK_DIV(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .leds      (leds),
    .running   (running),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == k between posedge k and posedge k+1.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic ex(input int c, input logic r, input logic y, input logic w, input logic [7:0] l);
    obs_t e;
    e.cyc = c; e.run = r; e.rdy = y; e.wr = w; e.led = l;
    sb_q.push_back(e);
  endtask

  // Vector on the accept cycle (ready low) and the ready recovery one cycle later.
  task automatic blip(input int a, input logic r, input logic w, input logic [7:0] l);
    ex(a, r, 1'b0, w, l);
    ex(a + 1, r, 1'b1, 1'b0, l);
  endtask

  // Drives a command from a negedge; returns the cycle of the accepting posedge.
  task automatic send(input logic [2:0] op, input logic [7:0] d, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    acc       = cyc;
    cmd_valid = 1'b0;
    if (n == 8) begin
      n_chk++;
      n_fail++;
      $display("FAIL handshake: cmd_ready stayed %b for 8 cycles, required 1", cmd_ready);
    end
  endtask

  initial begin : monitor
    logic [10:0] prev;
    logic [10:0] cur;
    obs_t        e;
    prev = 'x;
    #1;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      cur = {running, cmd_ready, wrap, leds};
      if (cur !== prev) begin
        prev = cur;
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_obs: cyc=%0d run/rdy/wrap/leds=%b/%b/%b/%0d, required no change",
                   cyc, running, cmd_ready, wrap, leds);
        end else begin
          e = sb_q.pop_front();
          if (e.cyc != cyc || cur !== {e.run, e.rdy, e.wr, e.led}) begin
            n_fail++;
            $display("FAIL obs: got cyc=%0d run/rdy/wrap/leds=%b/%b/%b/%0d, required cyc=%0d %b/%b/%b/%0d",
                     cyc, running, cmd_ready, wrap, leds, e.cyc, e.run, e.rdy, e.wr, e.led);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a;
    int t;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_data  = 8'd0;
    ex(1, 1'b0, 1'b1, 1'b0, 8'd0);          // reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Free run: ticks every 4 cycles, wrap after 7 -> 0.
    send(START, 8'd0, a);
    blip(a, 1'b1, 1'b0, 8'd0);
    for (int k = 1; k <= 7; k++) ex(a + 4 * k, 1'b1, 1'b1, 1'b0, 8'(k));
    ex(a + 32, 1'b1, 1'b1, 1'b1, 8'd0);
    ex(a + 33, 1'b1, 1'b1, 1'b0, 8'd0);
    ex(a + 36, 1'b1, 1'b1, 1'b0, 8'd1);
    ex(a + 40, 1'b1, 1'b1, 1'b0, 8'd2);
    repeat (40) @(negedge clk);

    send(STEP, 8'd0, t);  blip(t, 1'b1, 1'b0, 8'd2);   // STEP in RUN: no effect
    send(LOAD, 8'd5, t);  blip(t, 1'b1, 1'b0, 8'd5);   // lands on a tick edge
    send(STOP, 8'd0, t);  blip(t, 1'b0, 1'b0, 8'd5);
    send(LOAD, 8'd7, t);  blip(t, 1'b0, 1'b0, 8'd7);
    send(STEP, 8'd0, t);  blip(t, 1'b0, 1'b1, 8'd0);   // 7 -> 0 with wrap
    send(STEP, 8'd0, t);  blip(t, 1'b0, 1'b0, 8'd1);

    // Resume from frozen count with a cleared prescaler.
    send(START, 8'd0, a); blip(a, 1'b1, 1'b0, 8'd1); ex(a + 4, 1'b1, 1'b1, 1'b0, 8'd2);
    repeat (4) @(negedge clk);
    send(STOP, 8'd0, t);  blip(t, 1'b0, 1'b0, 8'd2);
    repeat (3) @(negedge clk);
    send(START, 8'd0, a); blip(a, 1'b1, 1'b0, 8'd2); ex(a + 4, 1'b1, 1'b1, 1'b0, 8'd3);
    repeat (4) @(negedge clk);
    send(STOP, 8'd0, t);  blip(t, 1'b0, 1'b0, 8'd3);

    // Limit handling.
    send(LOAD, 8'd6, t);   blip(t, 1'b0, 1'b0, 8'd6);
    send(SETLIM, 8'd3, t); blip(t, 1'b0, 1'b0, 8'd0);
    send(LOAD, 8'd5, t);   blip(t, 1'b0, 1'b0, 8'd0);
    send(LOAD, 8'd2, t);   blip(t, 1'b0, 1'b0, 8'd2);
    send(STEP, 8'd0, t);   blip(t, 1'b0, 1'b0, 8'd3);
    send(STEP, 8'd0, t);   blip(t, 1'b0, 1'b1, 8'd0);
    send(SETLIM, 8'd0, t); blip(t, 1'b0, 1'b0, 8'd0);
    send(STEP, 8'd0, t);   blip(t, 1'b0, 1'b1, 8'd0);  // limit 0 wraps every step
    send(SETLIM, 8'd7, t); blip(t, 1'b0, 1'b0, 8'd0);
    send(LOAD, 8'd4, t);   blip(t, 1'b0, 1'b0, 8'd4);
    send(CLEAR, 8'd0, t);  blip(t, 1'b0, 1'b0, 8'd0);
    send(NOP, 8'd0, t);    blip(t, 1'b0, 1'b0, 8'd0);

    // Asynchronous reset mid-RUN at leds=5.
    send(LOAD, 8'd5, t);  blip(t, 1'b0, 1'b0, 8'd5);
    send(START, 8'd0, a); blip(a, 1'b1, 1'b0, 8'd5);
    ex(a + 2, 1'b0, 1'b1, 1'b0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    // Command presented for the very first edge after reset release.
    rst_n     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = LOAD;
    cmd_data  = 8'd7;
    @(negedge clk);
    t         = cyc;
    cmd_valid = 1'b0;
    blip(t, 1'b0, 1'b0, 8'd7);                          // limit back to 7
    send(STEP, 8'd0, t);  blip(t, 1'b0, 1'b1, 8'd0);

`ifdef LED_SEQ_DIR_EN
    send(LOAD, 8'd1, t);   blip(t, 1'b0, 1'b0, 8'd1);
    send(TOGGLE, 8'd0, t); blip(t, 1'b0, 1'b0, 8'd1);
    send(START, 8'd0, a);  blip(a, 1'b1, 1'b0, 8'd1);
    ex(a + 4,  1'b1, 1'b1, 1'b0, 8'd0);
    ex(a + 8,  1'b1, 1'b1, 1'b1, 8'd7);
    ex(a + 9,  1'b1, 1'b1, 1'b0, 8'd7);
    ex(a + 12, 1'b1, 1'b1, 1'b0, 8'd6);
    repeat (12) @(negedge clk);
    send(STOP, 8'd0, t);   blip(t, 1'b0, 1'b0, 8'd6);
`else
    send(TOGGLE, 8'd0, t); blip(t, 1'b0, 1'b0, 8'd0);
    send(STEP, 8'd0, t);   blip(t, 1'b0, 1'b0, 8'd1);  // still counting up
`endif

    repeat (6) @(negedge clk);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_obs: %0d expected vectors never seen (next at cyc %0d), required 0",
               sb_q.size(), sb_q[0].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: clk cycles per count tick while running (legal range 2..2^24).
REQ-002 SHALL have parameter WIDTH, default 8: width of the count, limit and LED output.
REQ-003 SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command can be accepted.
REQ-007 SHALL have port cmd_op  input  3  opcode: 0 NOP, 1 START, 2 STOP, 3 STEP, 4 LOAD, 5 SET_LIMIT, 6 CLEAR, 7 TOGGLE_DIR.
REQ-008 SHALL have port cmd_data  input  WIDTH  operand for LOAD and SET_LIMIT.
REQ-009 SHALL have port leds  output  WIDTH  current count value.
REQ-010 SHALL have port running  output  1  high in RUN state.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on each wrap-around.

Function
REQ-012 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL be low for exactly the one cycle after each accept, high otherwise.
REQ-013 SHALL implement FSM states IDLE and RUN; START: IDLE->RUN; STOP: RUN->IDLE; all other ops leave state unchanged.
REQ-014 SHALL clear the prescaler on every START and LOAD; in RUN a tick SHALL occur when the prescaler reaches TICK_DIV-1, so the first increment lands TICK_DIV cycles after the START accept edge.
REQ-015 SHALL, on a tick (up direction), set leds to leds+1, or to 0 when leds == limit, pulsing wrap in the cycle after the update to 0.
REQ-016 STEP SHALL apply one tick update (REQ-015/REQ-025 rule, including wrap) on its accept edge in IDLE; in RUN it SHALL be accepted with no effect.
REQ-017 LOAD SHALL set leds to cmd_data if cmd_data <= limit, else to 0; state unchanged.
REQ-018 SET_LIMIT SHALL set limit to cmd_data; if current leds > new limit, leds SHALL become 0 on the same edge; limit 0 holds leds at 0 with wrap on every tick.
REQ-019 CLEAR SHALL set leds to 0 and clear the prescaler without changing state or limit.
REQ-020 When a command accept and a tick coincide, the command SHALL take effect and the tick SHALL be discarded.
REQ-021 STOP SHALL freeze leds and prescaler; a later START SHALL resume from the frozen leds with a cleared prescaler.
REQ-022 NOP SHALL be accepted (REQ-012 handshake applies) with no other effect.

Reset
REQ-023 SHALL, while rst_n is low, force leds=0, limit=7, state IDLE, prescaler=0, wrap=0, running=0, cmd_ready=1, direction up; asserting reset mid-RUN SHALL abort immediately.
REQ-024 SHALL resume normal operation on the first rising clk edge after rst_n deasserts, with no command lost or replayed.

Configuration
REQ-025 With macro LED_SEQ_DIR_EN defined, TOGGLE_DIR SHALL invert direction; in down direction a tick SHALL set leds to leds-1, or to limit when leds == 0, pulsing wrap.
REQ-026 Without LED_SEQ_DIR_EN, TOGGLE_DIR SHALL behave as NOP and the count SHALL be up-only, with no direction register.

Verification
REQ-027 Reset, START, run 40 cycles (TICK_DIV=4) -> leds 1,2..7,0,1,2 at 4-cycle spacing; wrap high exactly once after the 7->0 update.
REQ-028 IDLE with leds=7, STEP -> leds=0 and wrap pulse; STEP during RUN -> leds unchanged by the command.
REQ-029 leds=6, SET_LIMIT 3 -> leds=0, limit=3; then LOAD 5 -> leds=0; LOAD 2 -> leds=2.
REQ-030 Command accepted on the same edge as a tick -> command result visible, tick increment absent; cmd_ready low for one cycle after every accept.
REQ-031 rst_n pulsed low mid-RUN at leds=5 -> leds=0, running=0, limit=7 asynchronously, before the next clk edge.
REQ-032 With LED_SEQ_DIR_EN: leds=1, TOGGLE_DIR, START -> leds 0, 7, 6 on successive ticks with wrap after the 0->7 update; without the macro, TOGGLE_DIR -> no effect.
